rns53_reverse_conv: RTL
=======================

RNS53_REVERSE_CONV -- requirements
Module: rns53_reverse_conv

Interface
REQ-001 Parameters: none; all constants come from the shared package (REQ-034).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  residue pair offered.
REQ-005 in_ready  output  1  block can accept a pair.
REQ-006 in_r53  input  6  residue mod 53; legal range 0..52.
REQ-007 in_r64  input  6  residue mod 64, range 0..63.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_value  output  12  reconstructed X, range 0..3391.
REQ-011 out_err  output  1  the accepted in_r53 was illegal (≥53).

Function
REQ-012 The block SHALL convert the RNS pair {X mod 53, X mod 64} back to binary X, 0≤X<3392, by two-modulus mixed-radix conversion: X = 64·t + r64, where t = ((r53 − (r64 mod 53)) · 29) mod 53; 29 = 64⁻¹ mod 53.
REQ-013 FSM states SHALL be IDLE, SUB, MUL and DONE.
REQ-014 IDLE: in_ready=1; in_valid=1 SHALL latch in_r53/in_r64 and move to SUB; the accepting edge is called E0.
REQ-015 SUB (one cycle): d = (r53 − (r64 ≥ 53 ? r64−53 : r64)) mod 53, computed with a single conditional +53; then → MUL with step counter=4.
REQ-016 MUL (five cycles): Horner over 29 = 11101b, MSB first, acc starting at 0; each step acc ← red(red(2·acc) + (bit ? d : 0)).
REQ-017 red(v) for v≤104 SHALL be v−53 if v≥53, else v; no intermediate value SHALL exceed 7 bits.
REQ-018 After the fifth MUL step the FSM SHALL go to DONE, with out_valid=1 and out_value={acc[5:0], r64} (64·t + r64).
REQ-019 out_valid SHALL rise on edge E6 (fixed latency: 6 edges after E0).
REQ-020 DONE SHALL hold out_valid, out_value and out_err stable while out_ready=0.
REQ-021 DONE with out_ready=1: the FSM SHALL return to IDLE on that edge; out_valid=0 on the next cycle.
REQ-022 in_ready SHALL be 0 in SUB, MUL and DONE; there is no overlap of conversions.
REQ-023 in_valid in a non-IDLE state SHALL be ignored, with no latch and no state change.
REQ-024 Illegal in_r53 (≥53) SHALL still be accepted and take the same latency; the result SHALL be out_err=1 and out_value=0.
REQ-025 out_value SHALL be 0 whenever out_valid=0.
REQ-026 in_r64 ≥ 53 is legal; only its mod-53 image enters d.

Reset
REQ-027 rst=1 at an edge SHALL force state=IDLE, in_ready=1, out_valid=0, out_err=0 and out_value=0.
REQ-028 acc, d, the counter and the latched residues SHALL clear to 0 on reset.
REQ-029 Reset mid-conversion (SUB, MUL or DONE) SHALL abort it with no output; the next accepted pair converts correctly.
REQ-030 rst has priority over in_valid and out_ready on the same edge.

Structure
REQ-031 The datapath SHALL be a 7-bit accumulator, a 6-bit d register and a 3-bit step counter.
REQ-032 The datapath SHALL contain no multiplier and no division operator.
REQ-033 One sub-module, rns53_mod_addred, SHALL implement red(a+b) for a,b ≤ 52, holding a, b and the sum to 7 bits; doubling uses a=b=acc.
REQ-034 Package rns53_pkg SHALL hold MOD=53, INV64=29 (5'b11101), residue width 6, output width 12 and the FSM state enum.

Verification
REQ-035 X=0: in_r53=0, in_r64=0 → out_value=0, out_err=0, out_valid on E6.
REQ-036 X=400: in_r53=29, in_r64=16 → out_value=400 (d=13, t=6).
REQ-037 X=3391 boundary: in_r53=52, in_r64=63 → out_value=3391 (d=42, t=52).
REQ-038 Backpressure: X=1000 (in_r53=46, in_r64=40) with out_ready=0 for 5 cycles → out_value=1000 held stable; in_ready=0 and in_valid ignored throughout; IDLE one cycle after out_ready=1.
REQ-039 Illegal input: in_r53=53, in_r64=7 → out_err=1, out_value=0 on E6.
REQ-040 rst=1 during MUL step 3 → out_valid never rises; the next pair X=1000 converts correctly.
REQ-041 Exhaustive sweep of all 3392 legal pairs → every output matches X.

Source files
------------

// File: rtl/rns53_pkg.sv
// Shared constants and FSM state type for the mod-53 / mod-64 reverse converter.
package rns53_pkg;
  localparam int          RES_W = 6;
  localparam int          OUT_W = 12;
  localparam logic [5:0]  MOD   = 6'd53;
  localparam logic [4:0]  INV64 = 5'b11101;  // 64^-1 mod 53 = 29

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/rns53_reverse_conv_if.sv
// Input/output handshake bundle of the reverse converter.
interface rns53_reverse_conv_if;
  import rns53_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] in_r53;
  logic [RES_W-1:0] in_r64;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_value;
  logic             out_err;

  modport master (
    output in_valid, in_r53, in_r64, out_ready,
    input  in_ready, out_valid, out_value, out_err
  );

  modport slave (
    input  in_valid, in_r53, in_r64, out_ready,
    output in_ready, out_valid, out_value, out_err
  );
endinterface

// File: rtl/rns53_mod_addred.sv
// Modular add with a single conditional subtract: y = (a + b) mod 53 for a, b <= 52.
module rns53_mod_addred
  import rns53_pkg::*;
(
  input  logic [6:0] a,
  input  logic [6:0] b,
  output logic [6:0] y
);
  logic [6:0] sum;

  assign sum = a + b;
  assign y   = (sum >= {1'b0, MOD}) ? sum - {1'b0, MOD} : sum;
endmodule

// File: rtl/rns53_reverse_conv.sv
// Mixed-radix reverse converter: X = 64 * ((r53 - r64 mod 53) * 29 mod 53) + r64,
// with the multiply by 29 done as five Horner shift-add steps over its bits.
module rns53_reverse_conv
  import rns53_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  rns53_reverse_conv_if.slave  bus
);
  state_t           state;
  logic [RES_W-1:0] r53_q;
  logic [RES_W-1:0] r64_q;
  logic [RES_W-1:0] d;
  logic [6:0]       acc;
  logic [2:0]       cnt;
  logic             err_q;

  logic [5:0] r64_m;
  logic [6:0] diff;
  logic [6:0] d_next;
  logic [6:0] dbl;
  logic [6:0] addend;
  logic [6:0] acc_next;
  logic [4:0] inv_bits;

  // Subtraction mod 53: a borrow out of bit 6 means one +53 brings it back in range.
  assign r64_m  = (r64_q >= MOD) ? r64_q - MOD : r64_q;
  assign diff   = {1'b0, r53_q} - {1'b0, r64_m};
  assign d_next = diff[6] ? diff + {1'b0, MOD} : diff;

  assign inv_bits = INV64;
  assign addend   = inv_bits[cnt] ? {1'b0, d} : 7'd0;

  rns53_mod_addred u_double (.a(acc), .b(acc),    .y(dbl));
  rns53_mod_addred u_add    (.a(dbl), .b(addend), .y(acc_next));

  // NOTE: all state and registered outputs update with non-blocking assignments so
  // every branch below sees the pre-edge values of acc, cnt and the latched residues.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      r53_q         <= '0;
      r64_q         <= '0;
      d             <= '0;
      acc           <= '0;
      cnt           <= '0;
      err_q         <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_value <= '0;
      bus.out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            r53_q        <= bus.in_r53;
            r64_q        <= bus.in_r64;
            err_q        <= (bus.in_r53 >= MOD);
            bus.in_ready <= 1'b0;
            state        <= SUB;
          end
        end
        SUB: begin
          // An illegal r53 runs with d = 0 so the datapath stays in range; its result is masked.
          d     <= err_q ? '0 : d_next[5:0];
          acc   <= '0;
          cnt   <= 3'd4;
          state <= MUL;
        end
        MUL: begin
          acc <= acc_next;
          if (cnt == 3'd0) begin
            bus.out_valid <= 1'b1;
            bus.out_value <= err_q ? '0 : {acc_next[5:0], r64_q};
            bus.out_err   <= err_q;
            state         <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_value <= '0;
            bus.out_err   <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
